// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS controller: ALU function codes,
// opcode/funct encodings, FSM state enumeration and datapath select values.
package mips_ctrl_pkg;

  localparam int unsigned FUN_W = 6;
  localparam int unsigned SEL_W = 2;

  // ALU function codes
  localparam logic [FUN_W-1:0] ALU_ADD   = 6'b000000;
  localparam logic [FUN_W-1:0] ALU_SUB   = 6'b000001;
  localparam logic [FUN_W-1:0] ALU_AND   = 6'b011000;
  localparam logic [FUN_W-1:0] ALU_OR    = 6'b011110;
  localparam logic [FUN_W-1:0] ALU_XOR   = 6'b010110;
  localparam logic [FUN_W-1:0] ALU_NOR   = 6'b010001;
  localparam logic [FUN_W-1:0] ALU_PASSA = 6'b011010;
  localparam logic [FUN_W-1:0] ALU_SLL   = 6'b100000;
  localparam logic [FUN_W-1:0] ALU_SRL   = 6'b100001;
  localparam logic [FUN_W-1:0] ALU_SRA   = 6'b100011;
  localparam logic [FUN_W-1:0] ALU_EQ    = 6'b110011;
  localparam logic [FUN_W-1:0] ALU_NEQ   = 6'b110001;
  localparam logic [FUN_W-1:0] ALU_LT    = 6'b110101;
  localparam logic [FUN_W-1:0] ALU_LEZ   = 6'b111101;
  localparam logic [FUN_W-1:0] ALU_LTZ   = 6'b111011;
  localparam logic [FUN_W-1:0] ALU_GTZ   = 6'b111111;

  // Opcodes
  localparam logic [FUN_W-1:0] OP_RTYPE  = 6'h00;
  localparam logic [FUN_W-1:0] OP_REGIMM = 6'h01;
  localparam logic [FUN_W-1:0] OP_J      = 6'h02;
  localparam logic [FUN_W-1:0] OP_JAL    = 6'h03;
  localparam logic [FUN_W-1:0] OP_BEQ    = 6'h04;
  localparam logic [FUN_W-1:0] OP_BNE    = 6'h05;
  localparam logic [FUN_W-1:0] OP_BLEZ   = 6'h06;
  localparam logic [FUN_W-1:0] OP_BGTZ   = 6'h07;
  localparam logic [FUN_W-1:0] OP_ADDI   = 6'h08;
  localparam logic [FUN_W-1:0] OP_ADDIU  = 6'h09;
  localparam logic [FUN_W-1:0] OP_SLTI   = 6'h0A;
  localparam logic [FUN_W-1:0] OP_SLTIU  = 6'h0B;
  localparam logic [FUN_W-1:0] OP_ANDI   = 6'h0C;
  localparam logic [FUN_W-1:0] OP_ORI    = 6'h0D;
  localparam logic [FUN_W-1:0] OP_XORI   = 6'h0E;
  localparam logic [FUN_W-1:0] OP_LUI    = 6'h0F;
  localparam logic [FUN_W-1:0] OP_LW     = 6'h23;
  localparam logic [FUN_W-1:0] OP_SW     = 6'h2B;

  // R-type funct codes
  localparam logic [FUN_W-1:0] FN_SLL  = 6'h00;
  localparam logic [FUN_W-1:0] FN_SRL  = 6'h02;
  localparam logic [FUN_W-1:0] FN_SRA  = 6'h03;
  localparam logic [FUN_W-1:0] FN_JR   = 6'h08;
  localparam logic [FUN_W-1:0] FN_JALR = 6'h09;
  localparam logic [FUN_W-1:0] FN_ADD  = 6'h20;
  localparam logic [FUN_W-1:0] FN_ADDU = 6'h21;
  localparam logic [FUN_W-1:0] FN_SUB  = 6'h22;
  localparam logic [FUN_W-1:0] FN_SUBU = 6'h23;
  localparam logic [FUN_W-1:0] FN_AND  = 6'h24;
  localparam logic [FUN_W-1:0] FN_OR   = 6'h25;
  localparam logic [FUN_W-1:0] FN_XOR  = 6'h26;
  localparam logic [FUN_W-1:0] FN_NOR  = 6'h27;
  localparam logic [FUN_W-1:0] FN_SLT  = 6'h2A;
  localparam logic [FUN_W-1:0] FN_SLTU = 6'h2B;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC, S_ADDR, S_MEM_RD, S_MEM_WR,
    S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP, S_TRAP
  } state_e;

  // Datapath select values
  localparam logic [SEL_W-1:0] SRCA_PC    = 2'd0;
  localparam logic [SEL_W-1:0] SRCA_RS    = 2'd1;
  localparam logic [SEL_W-1:0] SRCA_SHAMT = 2'd2;
  localparam logic [SEL_W-1:0] SRCA_C16   = 2'd3;
  localparam logic [SEL_W-1:0] SRCB_RT    = 2'd0;
  localparam logic [SEL_W-1:0] SRCB_4     = 2'd1;
  localparam logic [SEL_W-1:0] SRCB_IMM   = 2'd2;
  localparam logic [SEL_W-1:0] SRCB_IMM4  = 2'd3;
  localparam logic [SEL_W-1:0] PCS_ALU    = 2'd0;
  localparam logic [SEL_W-1:0] PCS_ALUOUT = 2'd1;
  localparam logic [SEL_W-1:0] PCS_JUMP   = 2'd2;
  localparam logic [SEL_W-1:0] PCS_RS     = 2'd3;
  localparam logic [SEL_W-1:0] DST_RT     = 2'd0;
  localparam logic [SEL_W-1:0] DST_RD     = 2'd1;
  localparam logic [SEL_W-1:0] DST_RA     = 2'd2;
  localparam logic [SEL_W-1:0] M2R_ALU    = 2'd0;
  localparam logic [SEL_W-1:0] M2R_MDR    = 2'd1;
  localparam logic [SEL_W-1:0] M2R_PC     = 2'd2;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle.
// master: controller (drives ALU command, selects, strobes; reads memory/ALU status)
// slave : datapath/memory side (drives mem_rdata, mem_ready, alu_cmp)
interface mips_multicycle_ctrl_if;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        alu_cmp;
  logic [5:0]  alu_fun;
  logic        alu_sign;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic        ext_sign;
  logic        mem_read;
  logic        mem_write;
  logic        iord;
  logic        ir_write;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        reg_write;
  logic [1:0]  reg_dst;
  logic [1:0]  mem_to_reg;
  logic        illegal;

  modport master (
    input  mem_rdata, mem_ready, alu_cmp,
    output alu_fun, alu_sign, alu_src_a, alu_src_b, ext_sign, mem_read, mem_write,
           iord, ir_write, pc_write, pc_src, reg_write, reg_dst, mem_to_reg, illegal
  );

  modport slave (
    output mem_rdata, mem_ready, alu_cmp,
    input  alu_fun, alu_sign, alu_src_a, alu_src_b, ext_sign, mem_read, mem_write,
           iord, ir_write, pc_write, pc_src, reg_write, reg_dst, mem_to_reg, illegal
  );
endinterface

// File: rtl/alu_fun_decode.sv
// Combinational ALU command decode from (state, opcode, funct).
// Ports: i_state, i_opcode, i_funct in; o_alu_fun_c, o_alu_sign_c, o_ext_sign_c out.
module alu_fun_decode
  import mips_ctrl_pkg::*;
(
  input  state_e           i_state,
  input  logic [FUN_W-1:0] i_opcode,
  input  logic [FUN_W-1:0] i_funct,
  output logic [FUN_W-1:0] o_alu_fun_c,
  output logic             o_alu_sign_c,
  output logic             o_ext_sign_c
);

  always_comb begin
    o_alu_fun_c  = ALU_ADD;
    o_alu_sign_c = 1'b0;
    o_ext_sign_c = 1'b0;
    // Immediate extension only matters in states that route imm16 into the ALU
    if (i_state inside {S_DECODE, S_EXEC, S_ADDR})
      o_ext_sign_c = !(i_opcode inside {OP_ANDI, OP_ORI, OP_XORI});
    case (i_state)
      S_EXEC: begin
        if (i_opcode == OP_RTYPE) begin
          case (i_funct)
            FN_ADD:  begin o_alu_fun_c = ALU_ADD; o_alu_sign_c = 1'b1; end
            FN_ADDU: o_alu_fun_c = ALU_ADD;
            FN_SUB:  begin o_alu_fun_c = ALU_SUB; o_alu_sign_c = 1'b1; end
            FN_SUBU: o_alu_fun_c = ALU_SUB;
            FN_AND:  o_alu_fun_c = ALU_AND;
            FN_OR:   o_alu_fun_c = ALU_OR;
            FN_XOR:  o_alu_fun_c = ALU_XOR;
            FN_NOR:  o_alu_fun_c = ALU_NOR;
            FN_SLT:  begin o_alu_fun_c = ALU_LT; o_alu_sign_c = 1'b1; end
            FN_SLTU: o_alu_fun_c = ALU_LT;
            FN_SLL:  o_alu_fun_c = ALU_SLL;
            FN_SRL:  o_alu_fun_c = ALU_SRL;
            FN_SRA:  o_alu_fun_c = ALU_SRA;
            default: ;
          endcase
        end else begin
          case (i_opcode)
            OP_ADDI:  begin o_alu_fun_c = ALU_ADD; o_alu_sign_c = 1'b1; end
            OP_ADDIU: o_alu_fun_c = ALU_ADD;
            OP_SLTI:  begin o_alu_fun_c = ALU_LT; o_alu_sign_c = 1'b1; end
            OP_SLTIU: o_alu_fun_c = ALU_LT;
            OP_ANDI:  o_alu_fun_c = ALU_AND;
            OP_ORI:   o_alu_fun_c = ALU_OR;
            OP_XORI:  o_alu_fun_c = ALU_XOR;
            // lui = imm16 << 16, built as SLL with A = constant 16
            OP_LUI:   o_alu_fun_c = ALU_SLL;
            default: ;
          endcase
        end
      end
      S_BRANCH: begin
        o_alu_sign_c = 1'b1;
        case (i_opcode)
          OP_BEQ:  o_alu_fun_c = ALU_EQ;
          OP_BNE:  o_alu_fun_c = ALU_NEQ;
          OP_BLEZ: o_alu_fun_c = ALU_LEZ;
          OP_BGTZ: o_alu_fun_c = ALU_GTZ;
          default: o_alu_fun_c = ALU_LTZ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: owns IR and state, sequences the datapath.
// Ports: i_clk, i_reset (sync, active-high), io_bus (master modport carrying
// memory/ALU status inputs and all ALU command, select and strobe outputs).
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_reset,
  mips_multicycle_ctrl_if.master io_bus
);

  state_e      r_state, w_next;
  logic [31:0] r_ir;

  logic [FUN_W-1:0] w_op, w_fn, w_alu_fun;
  logic w_is_r, w_shift, w_r_alu, w_r_jump, w_i_alu, w_mem, w_branch, w_jump;
  logic w_alu_sign, w_ext_sign, w_mem_read, w_mem_write, w_iord, w_ir_write;
  logic w_pc_write, w_reg_write, w_illegal;
  logic [SEL_W-1:0] w_src_a, w_src_b, w_pc_src, w_reg_dst, w_mem_to_reg;
  logic w_unused_ir;

  assign w_op        = r_ir[31:26];
  assign w_fn        = r_ir[5:0];
  assign w_unused_ir = ^{r_ir[25:21], r_ir[15:6]};

  // Instruction classification; anything not matched traps
  assign w_is_r   = (w_op == OP_RTYPE);
  assign w_shift  = w_is_r && (w_fn inside {FN_SLL, FN_SRL, FN_SRA});
  assign w_r_alu  = w_shift || (w_is_r && (w_fn inside {FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
                    FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU}));
  assign w_r_jump = w_is_r && (w_fn inside {FN_JR, FN_JALR});
  assign w_i_alu  = w_op inside {OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
                                 OP_ANDI, OP_ORI, OP_XORI, OP_LUI};
  assign w_mem    = w_op inside {OP_LW, OP_SW};
  // REGIMM is only bltz (rt == 0)
  assign w_branch = (w_op inside {OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ}) ||
                    ((w_op == OP_REGIMM) && (r_ir[20:16] == 5'd0));
  assign w_jump   = (w_op inside {OP_J, OP_JAL}) || w_r_jump;

  // State and IR registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_FETCH;
      r_ir    <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_FETCH) && io_bus.mem_ready) r_ir <= io_bus.mem_rdata;
    end
  end

  alu_fun_decode u_alu_fun_decode (
    .i_state      (r_state),
    .i_opcode     (w_op),
    .i_funct      (w_fn),
    .o_alu_fun_c  (w_alu_fun),
    .o_alu_sign_c (w_alu_sign),
    .o_ext_sign_c (w_ext_sign)
  );

  // Next state and datapath controls
  always_comb begin
    w_next       = r_state;
    w_src_a      = SRCA_PC;
    w_src_b      = SRCB_RT;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_iord       = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_pc_src     = PCS_ALU;
    w_reg_write  = 1'b0;
    w_reg_dst    = DST_RT;
    w_mem_to_reg = M2R_ALU;
    w_illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_read = 1'b1;
        w_src_b    = SRCB_4;
        if (io_bus.mem_ready) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
          w_next     = S_DECODE;
        end
      end
      S_DECODE: begin
        w_src_b = SRCB_IMM4;
        if (w_r_alu || w_i_alu) w_next = S_EXEC;
        else if (w_mem)         w_next = S_ADDR;
        else if (w_branch)      w_next = S_BRANCH;
        else if (w_jump)        w_next = S_JUMP;
        else                    w_next = S_TRAP;
      end
      S_EXEC: begin
        if (w_is_r) begin
          w_src_a = w_shift ? SRCA_SHAMT : SRCA_RS;
          w_src_b = SRCB_RT;
        end else begin
          w_src_a = (w_op == OP_LUI) ? SRCA_C16 : SRCA_RS;
          w_src_b = SRCB_IMM;
        end
        w_next = S_WB_ALU;
      end
      S_ADDR: begin
        w_src_a = SRCA_RS;
        w_src_b = SRCB_IMM;
        w_next  = (w_op == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        w_mem_read = 1'b1;
        w_iord     = 1'b1;
        if (io_bus.mem_ready) w_next = S_WB_MEM;
      end
      S_MEM_WR: begin
        w_mem_write = 1'b1;
        w_iord      = 1'b1;
        if (io_bus.mem_ready) w_next = S_FETCH;
      end
      S_WB_ALU: begin
        w_reg_write = 1'b1;
        w_reg_dst   = w_is_r ? DST_RD : DST_RT;
        w_next      = S_FETCH;
      end
      S_WB_MEM: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = M2R_MDR;
        w_next       = S_FETCH;
      end
      S_BRANCH: begin
        w_src_a    = SRCA_RS;
        w_src_b    = SRCB_RT;
        w_pc_src   = PCS_ALUOUT;
        w_pc_write = io_bus.alu_cmp;
        w_next     = S_FETCH;
      end
      S_JUMP: begin
        w_pc_write = 1'b1;
        w_pc_src   = w_r_jump ? PCS_RS : PCS_JUMP;
        if ((w_op == OP_JAL) || (w_is_r && (w_fn == FN_JALR))) begin
          w_reg_write  = 1'b1;
          w_mem_to_reg = M2R_PC;
          w_reg_dst    = (w_op == OP_JAL) ? DST_RA : DST_RD;
        end
        w_next = S_FETCH;
      end
      S_TRAP: w_illegal = 1'b1;
      default: w_next = S_FETCH;
    endcase
  end

  // Every output is forced low while reset is held
  assign io_bus.alu_fun    = i_reset ? '0 : w_alu_fun;
  assign io_bus.alu_sign   = w_alu_sign   & ~i_reset;
  assign io_bus.alu_src_a  = i_reset ? '0 : w_src_a;
  assign io_bus.alu_src_b  = i_reset ? '0 : w_src_b;
  assign io_bus.ext_sign   = w_ext_sign   & ~i_reset;
  assign io_bus.mem_read   = w_mem_read   & ~i_reset;
  assign io_bus.mem_write  = w_mem_write  & ~i_reset;
  assign io_bus.iord       = w_iord       & ~i_reset;
  assign io_bus.ir_write   = w_ir_write   & ~i_reset;
  assign io_bus.pc_write   = w_pc_write   & ~i_reset;
  assign io_bus.pc_src     = i_reset ? '0 : w_pc_src;
  assign io_bus.reg_write  = w_reg_write  & ~i_reset;
  assign io_bus.reg_dst    = i_reset ? '0 : w_reg_dst;
  assign io_bus.mem_to_reg = i_reset ? '0 : w_mem_to_reg;
  assign io_bus.illegal    = w_illegal    & ~i_reset;

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multicycle control FSM for the 32-bit MIPS core. It fetches and decodes each instruction and sequences the datapath through fetch, decode, execute, memory and writeback. It is the producer side of the ALU command interface: it drives the 6-bit ALU function code and the signed/unsigned select, and consumes the ALU comparison bit to resolve branches. It also drives every datapath mux select and write enable.

## Interface
- No parameters.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- mem_rdata  in  32  instruction word from memory; sampled when FSM is in FETCH and mem_ready=1.
- mem_ready  in  1  memory access complete this cycle.
- alu_cmp  in  1  ALU result bit S[0], used for branch resolution.
- alu_fun  out  6  ALU function code.
- alu_sign  out  1  1 = signed compare/overflow semantics.
- alu_src_a  out  2  A operand: 0 = PC, 1 = rs, 2 = shamt, 3 = constant 16.
- alu_src_b  out  2  B operand: 0 = rt, 1 = constant 4, 2 = extended imm, 3 = extended imm<<2.
- ext_sign  out  1  1 = sign-extend imm16, 0 = zero-extend.
- mem_read, mem_write  out  1 each  memory strobes.
- iord  out  1  memory address: 0 = PC, 1 = ALUOut.
- ir_write, pc_write  out  1 each  register load enables.
- pc_src  out  2  next PC: 0 = ALU result, 1 = ALUOut, 2 = {PC[31:28], target, 2'b00}, 3 = rs.
- reg_write  out  1  register-file write enable.
- reg_dst  out  2  destination register: 0 = rt, 1 = rd, 2 = $31.
- mem_to_reg  out  2  write data: 0 = ALUOut, 1 = MDR, 2 = PC.
- illegal  out  1  unsupported opcode/funct trapped; sticky until reset.

## Operation
- ALU codes: ADD 000000, SUB 000001, AND 011000, OR 011110, XOR 010110, NOR 010001, PASSA 011010, SLL 100000, SRL 100001, SRA 100011, EQ 110011, NEQ 110001, LT 110101, LEZ 111101, LTZ 111011, GTZ 111111.
- Supported instructions:
  - R-type: add, addu, sub, subu, and, or, xor, nor, slt, sltu, sll, srl, sra, jr, jalr.
  - I-type: addi, addiu, andi, ori, xori, lui, slti, sltiu, lw, sw, beq, bne, blez, bgtz, bltz.
  - J-type: j, jal.
- alu_sign: 1 for add, sub, addi, slt, slti and all branches; 0 otherwise.
- ext_sign: 0 only for andi, ori and xori.
- lui: alu_src_a=3, alu_src_b=2, alu_fun=SLL.
- States and transitions:
  - FETCH: mem_read=1, iord=0. When mem_ready=1: ir_write=1, pc_write=1, ALU = PC+4 (src_a=0, src_b=1, ADD, pc_src=0), then go to DECODE. Otherwise stay in FETCH.
  - DECODE: compute branch target into ALUOut (src_a=0, src_b=3, ADD). Go to EXEC, ADDR, BRANCH or JUMP, or to TRAP on an unsupported opcode or funct.
  - EXEC: ALU operation per the instruction. Go to WB_ALU.
  - ADDR: rs + sign-extended imm, ADD. lw goes to MEM_RD; sw goes to MEM_WR.
  - MEM_RD: mem_read=1, iord=1; hold until mem_ready, then go to WB_MEM.
  - MEM_WR: mem_write=1, iord=1; hold until mem_ready, then go to FETCH.
  - WB_ALU: reg_write=1, mem_to_reg=0, reg_dst=1 (R-type) or 0 (I-type). Go to FETCH.
  - WB_MEM: reg_write=1, mem_to_reg=1, reg_dst=0. Go to FETCH.
  - BRANCH: beq uses EQ (src_b=0); bne uses NEQ; blez, bgtz and bltz use LEZ, GTZ and LTZ. If alu_cmp=1: pc_write=1, pc_src=1. Go to FETCH.
  - JUMP:
    - j/jal: pc_write=1, pc_src=2.
    - jr/jalr: pc_write=1, pc_src=3.
    - jal/jalr: also reg_write=1, mem_to_reg=2; reg_dst=2 for jal, 1 for jalr.
    - Go to FETCH.
  - TRAP: illegal=1, all strobes 0, no exit except reset.
- Default for every output not named in a state: 0.

## Timing
- reset=1 at a clock edge: state becomes FETCH and IR is cleared. All outputs are 0 while reset is high, including mem_read.
- Reset mid-operation aborts the instruction; no write strobe is issued in the reset cycle.
- Outputs are decoded from the state register and IR. Exceptions: ir_write and pc_write in FETCH, and the branch pc_write, also depend on mem_ready or alu_cmp in the same cycle.
- Cycle counts with zero wait states (mem_ready=1 on first request):
  - R/I ALU: 4.
  - lw: 5.
  - sw: 4.
  - Branch and jump: 3.
- Each cycle with mem_ready=0 adds one cycle; strobes stay stable while waiting.
- mem_ready is ignored outside FETCH, MEM_RD and MEM_WR.

## Structure
- Package mips_ctrl_pkg holds:
  - ALU function-code constants.
  - opcode and funct constants.
  - state enumeration.
  - src_a, src_b, pc_src, reg_dst and mem_to_reg select constants.
- Sub-module alu_fun_decode: combinational mapping of (state, opcode, funct) to {alu_fun, alu_sign, ext_sign}. The FSM owns the IR and state register.

## Test plan
- add $3,$1,$2 (0x00221820), mem_ready=1:
  - FETCH→DECODE→EXEC→WB_ALU in 4 cycles.
  - EXEC: alu_fun=000000, alu_sign=1.
  - WB_ALU: reg_write=1, reg_dst=1.
- lw $4,8($5) (0x8CA40008) with 2 wait cycles in MEM_RD: 7 cycles total; mem_read and iord held high for 3 cycles, then WB_MEM with mem_to_reg=1.
- beq (0x10220003): alu_fun=110011.
  - alu_cmp=1: pc_write=1, pc_src=1.
  - alu_cmp=0: pc_write=0; next state FETCH.
- jal 0x0C100000: JUMP asserts pc_src=2, reg_write=1, reg_dst=2, mem_to_reg=2.
- Opcode 0x3F: TRAP, illegal=1 held for 20 cycles. Then reset=1 for 1 cycle: FETCH, illegal=0.
- Reset asserted during MEM_WR: mem_write=0 in the reset cycle; the next cycle is FETCH with mem_read=1.
